bitboard_pack: RTL and testbench

- Stream-to-bitboard packer: accepts a valid/ready stream of square indices delimited by a last flag and ORs each square into a bitboard.
- Emits one completed bitboard plus its distinct-square count per packet.
- Inverse of the lowest-set-bit scanner. Move generators and board-setup logic stream squares in here; the packed bitboard feeds the attack/select logic that later scans it back out.
- Output is one register deep, so full throughput is kept while the consumer holds out_ready high.

---
 rtl/chess_pkg.sv | 21 ++
 rtl/sq_decode.sv | 12 +
 rtl/bitboard_pack.sv | 131 +++++++++++++
 tb/tb_bitboard_pack.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess-board types and constants: square index, bitboard and count widths,
// plus the output-hold state encoding used by the stream packer.
package chess_pkg;

    localparam int SQ_BITS  = 6;
    localparam int BB_WIDTH = 2 ** SQ_BITS;
    localparam int CNT_W    = SQ_BITS + 1;

    typedef logic [SQ_BITS-1:0]  sq_t;
    typedef logic [BB_WIDTH-1:0] bb_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    localparam sq_t SQ_A1 = sq_t'(0);
    localparam sq_t SQ_H8 = sq_t'(63);

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } pack_state_t;

endpackage

// File: rtl/sq_decode.sv
// Square index to one-hot bitboard decoder; purely combinational so the move
// generator can share it.
module sq_decode
    import chess_pkg::*;
(
    input  logic [SQ_BITS-1:0]  i_sq,
    output logic [BB_WIDTH-1:0] o_onehot
);

    assign o_onehot = bb_t'(1) << i_sq;

endmodule

// File: rtl/bitboard_pack.sv
// Stream-to-bitboard packer: ORs a valid/ready stream of squares into a bitboard per packet.
// Optional duplicate-square flag enabled by defining BITBOARD_PACK_DUP_CHECK_EN.
//
// state      | meaning
// HOLD_EMPTY | output register empty, out_valid low
// HOLD_FULL  | output register holds a completed packet, out_valid high
module bitboard_pack
    import chess_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SQ_BITS-1:0]  in_sq,
    input  logic                in_null,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BB_WIDTH-1:0] out_board,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_dup
);

    pack_state_t r_state;
    pack_state_t w_state_nxt;

    bb_t  r_acc;
    cnt_t r_acc_cnt;
    bb_t  r_out_board;
    cnt_t r_out_count;

    bb_t  w_sq_onehot;
    bb_t  w_beat_bit;
    bb_t  w_acc_nxt;
    cnt_t w_cnt_nxt;
    logic w_new_bit;
    logic w_fire;

    sq_decode u_sq_decode (
        .i_sq     (in_sq),
        .o_onehot (w_sq_onehot)
    );

    assign w_fire     = in_valid && in_ready;
    assign w_beat_bit = in_null ? '0 : w_sq_onehot;
    assign w_new_bit  = |(w_beat_bit & ~r_acc);
    assign w_acc_nxt  = r_acc | w_beat_bit;
    assign w_cnt_nxt  = r_acc_cnt + {{(CNT_W-1){1'b0}}, w_new_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HOLD_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HOLD_EMPTY: begin
                if (w_fire && in_last) begin
                    w_state_nxt = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                // a new last beat on the handshake edge refills the slot directly
                if (w_fire && in_last) begin
                    w_state_nxt = HOLD_FULL;
                end else if (out_ready) begin
                    w_state_nxt = HOLD_EMPTY;
                end
            end
            default: w_state_nxt = HOLD_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == HOLD_FULL);
        in_ready  = (r_state == HOLD_EMPTY) || out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_cnt   <= '0;
            r_out_board <= '0;
            r_out_count <= '0;
        end else if (w_fire) begin
            if (in_last) begin
                r_out_board <= w_acc_nxt;
                r_out_count <= w_cnt_nxt;
                r_acc       <= '0;
                r_acc_cnt   <= '0;
            end else begin
                r_acc     <= w_acc_nxt;
                r_acc_cnt <= w_cnt_nxt;
            end
        end
    end

    assign out_board = r_out_board;
    assign out_count = r_out_count;

`ifdef BITBOARD_PACK_DUP_CHECK_EN
    logic r_acc_dup;
    logic r_out_dup;
    logic w_dup_hit;

    assign w_dup_hit = !in_null && |(w_sq_onehot & r_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_dup <= 1'b0;
            r_out_dup <= 1'b0;
        end else if (w_fire) begin
            if (in_last) begin
                r_out_dup <= r_acc_dup | w_dup_hit;
                r_acc_dup <= 1'b0;
            end else begin
                r_acc_dup <= r_acc_dup | w_dup_hit;
            end
        end
    end

    assign out_dup = r_out_dup;
`else
    assign out_dup = 1'b0;
`endif

endmodule

// File: tb/tb_bitboard_pack.sv
// Randomized scoreboard bench for bitboard_pack; expected packets come from a set-based
// reference model. Define BITBOARD_PACK_DUP_CHECK_EN to expect the duplicate flag.
module tb_bitboard_pack;
    import chess_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_null = 1'b0;
    logic                in_last = 1'b0;
    logic                out_ready = 1'b1;
    logic [SQ_BITS-1:0]  in_sq = '0;
    logic                in_ready;
    logic                out_valid;
    logic                out_dup;
    logic [BB_WIDTH-1:0] out_board;
    logic [CNT_W-1:0]    out_count;

    always #5 clk = ~clk;

    bitboard_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sq     (in_sq),
        .in_null   (in_null),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_board (out_board),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    typedef struct packed {
        logic [BB_WIDTH-1:0] board;
        logic [CNT_W-1:0]    count;
        logic                dup;
    } exp_t;

    exp_t sb[$];
    int   pkt_sq[$];
    bit   pkt_nul[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   rand_ready = 1'b0;
    bit   watch_ready = 1'b0;
    int   ready_low = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // set-membership view of the packet: board = set of squares, count = set size
    function automatic exp_t model();
        exp_t e;
        bit   seen[64];
        int   cnt = 0;
        bit   dup = 1'b0;
        e = '0;
        foreach (seen[k]) seen[k] = 1'b0;
        foreach (pkt_sq[i]) begin
            if (!pkt_nul[i]) begin
                if (seen[pkt_sq[i]]) dup = 1'b1;
                else begin
                    seen[pkt_sq[i]] = 1'b1;
                    cnt++;
                end
            end
        end
        for (int k = 0; k < 64; k++) e.board[k] = seen[k];
        e.count = CNT_W'(cnt);
`ifdef BITBOARD_PACK_DUP_CHECK_EN
        e.dup = dup;
`else
        e.dup = 1'b0;
`endif
        return e;
    endfunction

    task automatic send_beat(int sq, bit nul, bit last);
        int t = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_sq    = SQ_BITS'(sq);
        in_null  = nul;
        in_last  = last;
        while (!acc && t < 200) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                pkt_sq.push_back(sq);
                pkt_nul.push_back(nul);
                if (last) begin
                    sb.push_back(model());
                    pkt_sq.delete();
                    pkt_nul.delete();
                end
            end
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: sq %0d never accepted", sq);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (watch_ready && !in_ready) ready_low++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got board 0x%0h count %0d, expected none",
                             out_board, out_count);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_board", out_board, e.board);
                    chk("out_count", 64'(out_count), 64'(e.count));
                    chk("out_dup", 64'(out_dup), 64'(e.dup));
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_board", out_board, 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_dup", 64'(out_dup), 64'd0);
        rst_n = 1'b1;
        idle(1);

        send_beat(0, 0, 0);
        send_beat(7, 0, 0);
        send_beat(63, 0, 1);
        @(negedge clk);
        chk("p1_valid", 64'(out_valid), 64'd1);
        chk("p1_board", out_board, 64'h8000_0000_0000_0081);
        chk("p1_count", 64'(out_count), 64'd3);
        @(negedge clk);
        chk("p1_valid_one_cycle", 64'(out_valid), 64'd0);
        idle(1);

        send_beat(12, 0, 0);
        send_beat(12, 0, 0);
        send_beat(28, 0, 1);
        send_beat(0, 1, 1);
        @(negedge clk);
        chk("null_valid", 64'(out_valid), 64'd1);
        chk("null_board", out_board, 64'd0);
        idle(2);

        out_ready = 1'b0;
        send_beat(5, 0, 1);
        fork
            send_beat(9, 0, 1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                    chk("bp_hold_board", out_board, 64'h20);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);

        watch_ready = 1'b1;
        for (int i = 0; i < 64; i++) send_beat(i, 0, i == 63);
        for (int i = 0; i < 64; i++) send_beat(int'($urandom_range(0, 63)), 0, 1);
        watch_ready = 1'b0;
        chk("full_rate_ready_low", 64'(ready_low), 64'd0);
        idle(3);

        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                bit nul;
                int sq;
                nul = ($urandom_range(0, 5) == 0);
                sq  = (p % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
                send_beat(sq, nul, b == len - 1);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle(4);

        out_ready = 1'b0;
        send_beat(40, 0, 1);
        idle(2);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_held_valid", 64'(out_valid), 64'd0);
        chk("rst_held_board", out_board, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);

        send_beat(20, 0, 0);
        send_beat(21, 0, 0);
        rst_n = 1'b0;
        pkt_sq.delete();
        pkt_nul.delete();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_beat(1, 0, 0);
        send_beat(2, 0, 1);
        @(negedge clk);
        chk("post_rst_board", out_board, 64'h6);
        chk("post_rst_count", 64'(out_count), 64'd2);
        idle(3);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
